// File: rtl/data_memory_ctrl.sv
// Multi-cycle big-endian data memory for the MIPS memory stage.
// Provides a req/ready/done handshake, configurable wait states and access fault reporting.
module data_memory_ctrl #(
  parameter int RAM_SIZE    = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_extend,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic        done,
  output logic        fault,
  output logic [31:0] read_data,
  output logic [7:0]  ram [RAM_SIZE]
);

  localparam int AW = $clog2(RAM_SIZE);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          we_q, sx_q, fault_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wd_q;

  logic          accept, access, req_fault;
  logic [32:0]   last_byte;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [31:0]   load_val;

  assign ready  = (state == IDLE);
  assign accept = (state == IDLE) && req;
  assign access = (state == BUSY) && (cnt == 4'd0);

  // The range check runs on a 33-bit sum so addresses near 2^32 cannot wrap into range.
  always_comb begin
    req_fault = 1'b0;
    last_byte = {1'b0, address};
    case (size)
      2'b00: last_byte = {1'b0, address};
      2'b01: begin
        last_byte = {1'b0, address} + 33'd1;
        if (address[0]) req_fault = 1'b1;
      end
      2'b10: begin
        last_byte = {1'b0, address} + 33'd3;
        if (address[1:0] != 2'b00) req_fault = 1'b1;
      end
      default: req_fault = 1'b1;
    endcase
    if (last_byte >= 33'(RAM_SIZE)) req_fault = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred;
  // clocked blocks use non-blocking '<=' so every register samples pre-edge values.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign a0 = addr_q;
  assign a1 = addr_q + AW'(1);
  assign a2 = addr_q + AW'(2);
  assign a3 = addr_q + AW'(3);

  always_comb begin
    load_val = '0;
    case (size_q)
      2'b00:   load_val = {{24{sx_q & ram[a0][7]}}, ram[a0]};
      2'b01:   load_val = {{16{sx_q & ram[a0][7]}}, ram[a0], ram[a1]};
      2'b10:   load_val = {ram[a0], ram[a1], ram[a2], ram[a3]};
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      sx_q      <= 1'b0;
      fault_q   <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wd_q      <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      read_data <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      if (accept) begin
        we_q    <= we;
        sx_q    <= sign_extend;
        size_q  <= size;
        addr_q  <= address[AW-1:0];
        wd_q    <= write_data;
        fault_q <= req_fault;
        cnt     <= 4'(WAIT_STATES);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        done      <= 1'b1;
        fault     <= fault_q;
        read_data <= (fault_q || we_q) ? 32'd0 : load_val;
      end
    end
  end

  // NOTE: the storage array has no reset; clearing it would need a write port per byte.
  // A reset mid-access forces state to IDLE asynchronously, so 'access' can never fire.
  always_ff @(posedge clk) begin
    if (access && we_q && !fault_q) begin
      case (size_q)
        2'b00: ram[a0] <= wd_q[7:0];
        2'b01: begin
          ram[a0] <= wd_q[15:8];
          ram[a1] <= wd_q[7:0];
        end
        2'b10: begin
          ram[a0] <= wd_q[31:24];
          ram[a1] <= wd_q[23:16];
          ram[a2] <= wd_q[15:8];
          ram[a3] <= wd_q[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances with 0, 2 and 3 wait states,
// table-driven accesses with a result scoreboard plus reset and latency sequences.
module tb_data_memory_ctrl;

  localparam int RS = 1024;

  logic        clk = 1'b0;
  logic [2:0]  rst_v = 3'b111;
  logic [2:0]  req_v = 3'b000;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sx = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [2:0]  ready_v, done_v, fault_v;
  logic [31:0] rd_v [3];
  logic [7:0]  ram0 [RS];
  logic [7:0]  ram1 [RS];
  logic [7:0]  ram2 [RS];

  always #5 clk = ~clk;

  data_memory_ctrl #(.RAM_SIZE(RS), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .we(we), .size(size), .sign_extend(sx),
    .address(address), .write_data(write_data), .ready(ready_v[0]), .done(done_v[0]),
    .fault(fault_v[0]), .read_data(rd_v[0]), .ram(ram0));
  data_memory_ctrl #(.RAM_SIZE(RS), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .we(we), .size(size), .sign_extend(sx),
    .address(address), .write_data(write_data), .ready(ready_v[1]), .done(done_v[1]),
    .fault(fault_v[1]), .read_data(rd_v[1]), .ram(ram1));
  data_memory_ctrl #(.RAM_SIZE(RS), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst_v[2]), .req(req_v[2]), .we(we), .size(size), .sign_extend(sx),
    .address(address), .write_data(write_data), .ready(ready_v[2]), .done(done_v[2]),
    .fault(fault_v[2]), .read_data(rd_v[2]), .ram(ram2));

  typedef struct {
    int          inst;
    logic        we;
    logic [1:0]  size;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_fault;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  typedef struct {
    logic        fault;
    logic [31:0] rd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic int ws_of(input int inst);
    case (inst)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] ram_byte(input int inst, input int a);
    case (inst)
      0:       return ram0[a];
      1:       return ram1[a];
      default: return ram2[a];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input int inst, input logic w, input logic [1:0] sz, input logic s,
                     input logic [31:0] a, input logic [31:0] d, input logic ef,
                     input logic [31:0] er, input string nm);
    vec_t v;
    v.inst = inst; v.we = w; v.size = sz; v.sx = s; v.addr = a; v.wd = d;
    v.exp_fault = ef; v.exp_rd = er; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    we = v.we; size = v.size; sx = v.sx; address = v.addr; write_data = v.wd;
  endtask

  // One complete access: wait for ready, request, then check latency and result at done.
  task automatic run_access(input vec_t v);
    int   cyc;
    exp_t e;
    @(negedge clk);
    cyc = 0;
    while (!ready_v[v.inst] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s ready_before", v.name), 32'(ready_v[v.inst]), 32'd1);
    drive(v);
    req_v[v.inst] = 1'b1;
    sb.push_back('{fault: v.exp_fault, rd: v.exp_rd});
    @(posedge clk);
    @(negedge clk);
    req_v[v.inst] = 1'b0;
    cyc = 1;
    while (!done_v[v.inst] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    check($sformatf("%s latency", v.name), 32'(cyc), 32'(ws_of(v.inst) + 2));
    check($sformatf("%s fault", v.name), 32'(fault_v[v.inst]), 32'(e.fault));
    check($sformatf("%s read_data", v.name), rd_v[v.inst], e.rd);
    check($sformatf("%s ready_at_done", v.name), 32'(ready_v[v.inst]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    exp_t e;
    int   cyc;

    // Word round trip, byte/half loads, faults, boundary and partial store rows.
    add(0, 1, 2'b10, 0, 32'h20, 32'h11223344, 0, 32'h0,        "st_w_20");
    add(0, 0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h11223344, "ld_w_20");
    add(0, 1, 2'b10, 0, 32'h40, 32'h80FF7F01, 0, 32'h0,        "st_w_40");
    add(0, 0, 2'b00, 1, 32'h40, 32'h0,        0, 32'hFFFFFF80, "ld_bs_40");
    add(0, 0, 2'b00, 0, 32'h40, 32'h0,        0, 32'h00000080, "ld_bu_40");
    add(0, 0, 2'b01, 1, 32'h42, 32'h0,        0, 32'h00007F01, "ld_hs_42");
    add(0, 0, 2'b01, 1, 32'h40, 32'h0,        0, 32'hFFFF80FF, "ld_hs_40");
    add(0, 0, 2'b01, 0, 32'h40, 32'h0,        0, 32'h000080FF, "ld_hu_40");
    add(0, 1, 2'b01, 0, 32'h41, 32'hBEEF,     1, 32'h0,        "st_h_41_fault");
    add(0, 0, 2'b10, 0, 32'h40, 32'h0,        0, 32'h80FF7F01, "ld_w_40_after_fault");
    add(0, 0, 2'b10, 0, 32'h42, 32'h0,        1, 32'h0,        "ld_w_42_fault");
    add(0, 0, 2'b11, 0, 32'h40, 32'h0,        1, 32'h0,        "size11_fault");
    add(0, 0, 2'b10, 0, RS - 2, 32'h0,        1, 32'h0,        "ld_w_top2_fault");
    add(0, 1, 2'b10, 0, RS - 4, 32'hCAFEF00D, 0, 32'h0,        "st_w_top4");
    add(0, 0, 2'b10, 0, RS - 4, 32'h0,        0, 32'hCAFEF00D, "ld_w_top4");
    add(0, 0, 2'b10, 0, 32'hFFFFFFFC, 32'h0,  1, 32'h0,        "ld_w_wrap_fault");
    add(0, 0, 2'b00, 0, RS,     32'h0,        1, 32'h0,        "ld_b_size_fault");
    add(0, 0, 2'b01, 0, RS - 2, 32'h0,        0, 32'h0000F00D, "ld_h_top2");
    add(0, 1, 2'b10, 0, 32'h50, 32'h0,        0, 32'h0,        "st_w_50_zero");
    add(0, 1, 2'b00, 0, 32'h51, 32'h123456AB, 0, 32'h0,        "st_b_51");
    add(0, 0, 2'b10, 0, 32'h50, 32'h0,        0, 32'h00AB0000, "ld_w_50");
    add(1, 1, 2'b10, 0, 32'h70, 32'hA5A55A5A, 0, 32'h0,        "ws2_st_w_70");
    add(1, 0, 2'b01, 0, 32'h72, 32'h0,        0, 32'h00005A5A, "ws2_ld_h_72");

    // Reset state of all instances while rst is held.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset ready[%0d]", i), 32'(ready_v[i]), 32'd1);
      check($sformatf("reset done[%0d]", i),  32'(done_v[i]),  32'd0);
      check($sformatf("reset fault[%0d]", i), 32'(fault_v[i]), 32'd0);
      check($sformatf("reset rd[%0d]", i),    rd_v[i],         32'd0);
    end
    @(negedge clk);
    rst_v = 3'b000;

    for (int i = 0; i < vecs.size(); i++) run_access(vecs[i]);

    check("ram20", 32'({ram0[32'h20], ram0[32'h21], ram0[32'h22], ram0[32'h23]}), 32'h11223344);
    check("ram41_after_fault", 32'({ram0[32'h41], ram0[32'h42]}), 32'hFF7F);
    check("ram50_partial", 32'({ram0[32'h50], ram0[32'h51], ram0[32'h52], ram0[32'h53]}),
          32'h00AB0000);

    // Reset mid-access on the two-wait-state instance.
    v = '{inst: 1, we: 1, size: 2'b10, sx: 0, addr: 32'h10, wd: 32'h01020304,
          exp_fault: 0, exp_rd: 32'h0, name: "ws2_pre_st"};
    run_access(v);
    v.we = 0; v.exp_rd = 32'h01020304; v.name = "ws2_pre_ld";
    run_access(v);
    @(negedge clk);
    v.we = 1; v.wd = 32'hDEADBEEF;
    drive(v);
    req_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_v[1] = 1'b0;
    check("abort busy", 32'(ready_v[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_v[1] = 1'b1;
    #1;
    check("abort ready", 32'(ready_v[1]), 32'd1);
    check("abort done",  32'(done_v[1]),  32'd0);
    check("abort fault", 32'(fault_v[1]), 32'd0);
    check("abort rd",    rd_v[1],         32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort in_rst done%0d", k), 32'(done_v[1]), 32'd0);
    end
    rst_v[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("abort post done%0d", k), 32'(done_v[1]), 32'd0);
    end
    check("abort ram10", 32'({ram_byte(1, 32'h10), ram_byte(1, 32'h11),
                              ram_byte(1, 32'h12), ram_byte(1, 32'h13)}), 32'h01020304);

    // Three wait states with req held high: ready low for four samples, then back-to-back accept.
    v = '{inst: 2, we: 1, size: 2'b10, sx: 0, addr: 32'h30, wd: 32'h0A0B0C0D,
          exp_fault: 0, exp_rd: 32'h0, name: "ws3_pre_st"};
    run_access(v);
    @(negedge clk);
    v.we = 0; v.wd = 32'h0;
    drive(v);
    req_v[2] = 1'b1;
    sb.push_back('{fault: 1'b0, rd: 32'h0A0B0C0D});
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("ws3 busy ready%0d", k), 32'(ready_v[2]), 32'd0);
      check($sformatf("ws3 busy done%0d", k),  32'(done_v[2]),  32'd0);
    end
    @(negedge clk);
    e = sb.pop_front();
    check("ws3 done",  32'(done_v[2]),  32'd1);
    check("ws3 ready", 32'(ready_v[2]), 32'd1);
    check("ws3 fault", 32'(fault_v[2]), 32'(e.fault));
    check("ws3 rd",    rd_v[2],         e.rd);
    sb.push_back('{fault: 1'b0, rd: 32'h0A0B0C0D});
    @(posedge clk);
    @(negedge clk);
    req_v[2] = 1'b0;
    check("ws3 done_one_cycle", 32'(done_v[2]),  32'd0);
    check("ws3 b2b_accepted",   32'(ready_v[2]), 32'd0);
    cyc = 1;
    while (!done_v[2] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    check("ws3 b2b latency", 32'(cyc), 32'd5);
    check("ws3 b2b rd", rd_v[2], e.rd);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
